// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared triangle bus widths, slot indices and pack FSM states
package gpu_pkg;

  localparam int WORD_W        = 32;
  localparam int WORDS_PER_TRI = 15;
  localparam int COORD_W       = 10;
  localparam int IDX_W         = $clog2(WORDS_PER_TRI);

  // Vertex coordinate slots within a triangle bundle; attributes follow
  localparam int VERTEX_SLOT_V0X = 0;
  localparam int VERTEX_SLOT_V0Y = 1;
  localparam int VERTEX_SLOT_V1X = 2;
  localparam int VERTEX_SLOT_V1Y = 3;
  localparam int VERTEX_SLOT_V2X = 4;
  localparam int VERTEX_SLOT_V2Y = 5;

  typedef logic [WORD_W*WORDS_PER_TRI-1:0] tri_bus_t;

  typedef enum logic {
    FILL = 1'b0,
    HELD = 1'b1
  } pack_state_e;

endpackage

// File: rtl/vertex_pack.sv
// rtl/vertex_pack.sv - assembles a vertex word stream into flat triangle bundles
module vertex_pack
  import gpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  output logic              tri_valid,
  input  logic              tri_ready,
  output tri_bus_t          tri_data,
  output logic [15:0]       tri_count,
  output logic              err_short,
  output logic              err_long,
  output logic              coord_ovf
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS_PER_TRI - 1);
  localparam logic [IDX_W-1:0] COORD_MAX = IDX_W'(VERTEX_SLOT_V2Y);

  pack_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  tri_bus_t         asm_q, asm_d;
  tri_bus_t         data_q, data_d;
  logic             valid_q, valid_d;
  logic [15:0]      count_q, count_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             out_free;
  logic             complete;
  tri_bus_t         asm_word;

  // A coordinate fits when every bit from the sign bit of COORD_W upward agrees
  function automatic logic coord_fits(input logic [WORD_W-1:0] w);
    logic [WORD_W-COORD_W:0] top;
    top = w[WORD_W-1:COORD_W-1];
    return (top == '0) || (&top);
  endfunction

  assign s_ready   = (state_q == FILL);
  assign tri_valid = valid_q;
  assign tri_data  = data_q;
  assign tri_count = count_q;
  assign err_short = short_q;
  assign err_long  = long_q;
  assign coord_ovf = ovf_q;

  // Next-state: word placement, bundle completion, output handoff and error pulses
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    asm_d    = asm_q;
    data_d   = data_q;
    valid_d  = valid_q;
    count_d  = count_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    ovf_d    = 1'b0;
    accept   = s_valid && (state_q == FILL);
    out_free = !valid_q || tri_ready;
    complete = 1'b0;
    asm_word = asm_q;
    asm_word[int'(idx_q)*WORD_W +: WORD_W] = s_data;

    if (valid_q && tri_ready) begin
      valid_d = 1'b0;
      count_d = count_q + 16'd1;
    end

    case (state_q)
      FILL: begin
        if (accept) begin
          complete = s_last || (idx_q == LAST_IDX);
          short_d  = s_last && (idx_q != LAST_IDX);
          long_d   = !s_last && (idx_q == LAST_IDX);
          ovf_d    = (idx_q <= COORD_MAX) && !coord_fits(s_data);
          if (complete) begin
            // Unwritten upper slots are already zero since the assembly reg starts clear
            idx_d = '0;
            if (out_free) begin
              data_d  = asm_word;
              valid_d = 1'b1;
              asm_d   = '0;
            end else begin
              asm_d   = asm_word;
              state_d = HELD;
            end
          end else begin
            idx_d = idx_q + 1'b1;
            asm_d = asm_word;
          end
        end
      end
      HELD: begin
        // Output is occupied here, so tri_ready means the current bundle leaves this edge
        if (tri_ready) begin
          data_d  = asm_q;
          valid_d = 1'b1;
          asm_d   = '0;
          idx_d   = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      asm_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
      short_q <= short_d;
      long_q  <= long_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_vertex_pack.sv
// tb/tb_vertex_pack.sv - scoreboard bench for vertex_pack with directed and random streams
module tb_vertex_pack;
  import gpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        tri_valid;
  logic        tri_ready = 1'b0;
  tri_bus_t    tri_data;
  logic [15:0] tri_count;
  logic        err_short;
  logic        err_long;
  logic        coord_ovf;

  vertex_pack dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_data(tri_data),
    .tri_count(tri_count), .err_short(err_short), .err_long(err_long),
    .coord_ovf(coord_ovf)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_miss = 0;
  tri_bus_t    expq[$];
  logic [31:0] cur[$];
  int          outs = 0;
  logic        exp_short = 1'b0;
  logic        exp_long = 1'b0;
  logic        exp_ovf = 1'b0;
  bit          last_acc = 1'b0;
  bit          rand_ready = 1'b0;
  bit          mon_en = 1'b0;
  int          hand_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every handoff must match the oldest predicted bundle
  always @(negedge clk) begin
    tri_bus_t e;
    if (mon_en && rst_n && tri_valid && tri_ready) begin
      n_vec++;
      if (expq.size() == 0) begin
        n_miss++;
        $display("FAIL bundle: unexpected handoff got %h", tri_data);
      end else begin
        e = expq.pop_front();
        if (tri_data !== e) begin
          n_miss++;
          $display("FAIL bundle: got %h expected %h", tri_data, e);
        end
      end
      chk("tri_count", 64'(tri_count), 64'(hand_cnt & 32'hFFFF));
      hand_cnt++;
    end
  end

  // One clock: check handshake/pulses, advance the triangle model, step past the edge
  task automatic tick();
    bit          acc;
    bit          hand;
    bit          comp;
    int          idx;
    int signed   v;
    tri_bus_t    b;
    if (rand_ready) tri_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    chk("err_short", 64'(err_short), 64'(exp_short));
    chk("err_long", 64'(err_long), 64'(exp_long));
    chk("coord_ovf", 64'(coord_ovf), 64'(exp_ovf));
    chk("tri_valid", 64'(tri_valid), 64'(outs > 0));
    chk("s_ready", 64'(s_ready), 64'(outs < 2));
    acc  = s_valid && (outs < 2);
    hand = (outs > 0) && tri_ready;
    exp_short = 1'b0;
    exp_long  = 1'b0;
    exp_ovf   = 1'b0;
    last_acc  = acc;
    if (acc) begin
      idx = cur.size();
      cur.push_back(s_data);
      v = $signed(s_data);
      comp      = s_last || (idx == WORDS_PER_TRI - 1);
      exp_short = s_last && (idx < WORDS_PER_TRI - 1);
      exp_long  = !s_last && (idx == WORDS_PER_TRI - 1);
      exp_ovf   = (idx <= 5) && (v < -512 || v > 511);
      if (comp) begin
        b = '0;
        for (int k = 0; k < cur.size(); k++) b[k*WORD_W +: WORD_W] = cur[k];
        expq.push_back(b);
        cur.delete();
        outs++;
      end
    end
    if (hand) outs--;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    last_acc = 1'b0;
    for (int t = 0; t < 200; t++) begin
      tick();
      if (last_acc) break;
    end
    n_vec++;
    if (!last_acc) begin
      n_miss++;
      $display("FAIL send_timeout: word %0h not accepted within 200 cycles", d);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = $urandom;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    #1;
    chk("rst_tri_valid", 64'(tri_valid), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_tri_count", 64'(tri_count), 64'd0);
    chk("rst_tri_data_zero", 64'(tri_data == '0), 64'd1);
    chk("rst_pulses", 64'({err_short, err_long, coord_ovf}), 64'd0);
    cur.delete();
    expq.delete();
    outs = 0;
    exp_short = 1'b0;
    exp_long  = 1'b0;
    exp_ovf   = 1'b0;
    hand_cnt  = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic send_tri(input int n, input logic last_on_final, input int base);
    for (int i = 0; i < n; i++) send(32'(base + i), last_on_final && (i == n - 1));
  endtask

  initial begin
    int coords[6];
    logic [31:0] d;
    #1;
    do_reset();

    // Nominal triangle with free output
    tri_ready = 1'b1;
    coords = '{20, 20, 30, 20, 25, 30};
    for (int i = 0; i < 6; i++) send(32'(coords[i]), 1'b0);
    for (int i = 0; i < 9; i++) send(32'(100 + i), i == 8);
    idle(2);
    chk("t1_count", 64'(tri_count), 64'd1);

    // Backpressure: second triangle parks in HELD until tri_ready rises
    tri_ready = 1'b0;
    send_tri(15, 1'b1, 200);
    send_tri(15, 1'b1, 300);
    idle(1);
    chk("t2_held_s_ready", 64'(s_ready), 64'd0);
    tri_ready = 1'b1;
    idle(3);
    chk("t2_count", 64'(tri_count), 64'd3);
    chk("t2_s_ready", 64'(s_ready), 64'd1);

    // Short triangle: s_last on word 5
    send_tri(6, 1'b1, 400);
    idle(2);
    // Long triangle then a normal one starting at slot 0
    send_tri(15, 1'b0, 500);
    send_tri(15, 1'b1, 600);
    idle(2);

    // Coordinate range: 600 overflows, -5 does not
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd600, 1'b0);
    send(32'hFFFF_FFFB, 1'b0);
    send(32'h0000_01FF, 1'b0);
    send(32'hFFFF_FE00, 1'b0);
    send_tri(9, 1'b1, 700);
    idle(2);
    chk("t5_count", 64'(tri_count), 64'd7);

    // Reset mid-triangle discards the partial words
    send_tri(7, 1'b0, 800);
    do_reset();
    tri_ready = 1'b1;
    send_tri(15, 1'b1, 900);
    idle(2);
    chk("t6_count", 64'(tri_count), 64'd1);

    // Random streams with random gaps, lengths and backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        s_data = $urandom;
        tick();
      end else begin
        if ($urandom_range(0, 2) == 0) d = $urandom;
        else d = 32'($urandom_range(0, 1100)) - 32'd550;
        send(d, $urandom_range(0, 13) == 0);
      end
    end
    rand_ready = 1'b0;
    tri_ready  = 1'b1;
    idle(40);
    chk("drain_empty", 64'(expq.size()), 64'd0);
    chk("drain_valid", 64'(tri_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
